key_debounce_bank: RTL and testbench
====================================

// Module: key_debounce_bank
// PURPOSE
//  Parametrised multi-channel debouncer for board push-buttons and DIP switches.
//  Each channel has a 2-flop synchroniser, a glitch-aborting settle counter, and one-cycle press/release strobes.
//  Sits between the raw FPGA pins and the vending FSM / coin-input logic, replacing per-key single-bit debouncers.
// PARAMETERS
//  N_KEYS          4          number of independent channels
//  DEBOUNCE_CYCLES 1_000_000  settle time in clk cycles (20 ms @ 50 MHz); legal range >= 2
//  ACTIVE_LOW      0          1: raw pin reads 0 when pressed; the block inverts it at the synchroniser input
//  LONG_CYCLES     50_000_000 hold time for the long-press strobe (1 s @ 50 MHz); used only with KEY_LONGPRESS_EN
//  Counter widths are derived with $clog2 from the parameters (localparams, not overridable).
// PORTS
//  clk          in   1       system clock
//  nrst         in   1       asynchronous active-low reset
//  key_in       in   N_KEYS  raw asynchronous key/switch pins
//  key_out      out  N_KEYS  debounced level, 1 = pressed, regardless of ACTIVE_LOW
//  key_press    out  N_KEYS  1-cycle strobe when key_out goes 0->1
//  key_release  out  N_KEYS  1-cycle strobe when key_out goes 1->0
//  key_long     out  N_KEYS  1-cycle strobe after key_out has been 1 for LONG_CYCLES cycles
//  key_busy     out  1       OR over channels of (state == CHECK)
// BEHAVIOUR
//  Reset (nrst=0, async): all outputs 0. Sync flops load the released level. All counters are 0 and all states are IDLE.
//   No press strobe follows reset deassertion, even if a key is held at that time.
//  Reset mid-CHECK aborts silently. No strobe is emitted.
//  Per channel k (all channels are fully independent), where s2 = second sync flop after ACTIVE_LOW inversion:
//   IDLE : if s2 != key_out[k], go to CHECK with cnt=0; otherwise stay.
//   CHECK: if s2 == key_out[k] (bounce or glitch returned), go to IDLE with cnt=0. No output change.
//          else if cnt == DEBOUNCE_CYCLES-1, then:
//            key_out[k] <= s2;
//            pulse key_press[k] (if s2=1) or key_release[k] (if s2=0) for exactly 1 cycle, registered;
//            go to IDLE with cnt=0.
//          else cnt <= cnt+1.
//  Latency: when key_in is clean-stepped before clk edge E0, key_out and the strobe update at edge E0+DEBOUNCE_CYCLES+3.
//  Any reversion during the window restarts the full window. A committed value is always one that was held continuously.
//  key_press and key_release for one channel are never both 1 in the same cycle. Different channels may strobe simultaneously.
//  The counter never wraps: it saturates logically through the exit at DEBOUNCE_CYCLES-1.
// CONFIGURATION
//  KEY_LONGPRESS_EN defined:
//   A per-channel hold counter runs while key_out[k]=1 and clears to 0 when key_out[k]=0.
//   When the count reaches LONG_CYCLES-1, key_long[k] pulses for 1 cycle.
//   The hold counter then stops: at most one key_long per press, and it does not wrap.
//   If the release commits in the same cycle as the threshold, the release wins and no key_long is emitted.
//  KEY_LONGPRESS_EN undefined: key_long is tied to 0, and no hold counters are synthesised.
// TESTING  (bench: N_KEYS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=0)
//  1. Reset, then hold key_in=4'b0001 from edge E0 -> key_out=0001 and key_press=0001 for one cycle at E0+7. key_busy=1 during CHECK.
//  2. key_in[1] high for 3 cycles then low (glitch) -> key_out[1] stays 0. No strobe. Channel returns to IDLE.
//  3. key_in[2] bounces 1,0,1,1,1,1,1... -> commit 7 cycles after the last 0->1 edge. Exactly one key_press[2].
//  4. Keys 0 and 3 released on the same edge -> key_release=1001 for one cycle. key_out=0000.
//  5. With KEY_LONGPRESS_EN: hold key 0 for 40 cycles after commit -> exactly one key_long[0], 16 cycles after key_press[0].
//     Without KEY_LONGPRESS_EN: key_long stays 0.
//  6. Assert nrst mid-CHECK on key 1 with key held, then release nrst -> all outputs stay 0 until a new full window elapses.
//     Re-run case 1 with ACTIVE_LOW=1 and inverted stimulus: identical outputs are required.

Source files
------------

// File: rtl/key_debounce_bank.sv
// Multi-channel key/switch debouncer: 2-flop sync, glitch-aborting settle window, press/release strobes.
// Optional long-press strobe is built only when KEY_LONGPRESS_EN is defined.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACTIVE_LOW      = 0,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CHECK = 1'b1;

  logic          raw;
  logic          s1_q, s2_q;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          out_q, press_q, rel_q;

  assign raw = (ACTIVE_LOW != 0) ? ~key_in : key_in;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE: if (s2_q != lvl_q) begin
        state_d = CHECK;
        cnt_d   = '0;
      end
      default: begin
        if (s2_q == lvl_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          lvl_d   = s2_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Outputs are a registered copy of the committed level; strobes are its edges.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      out_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      out_q   <= lvl_q;
      press_q <= lvl_q & ~out_q;
      rel_q   <= ~lvl_q & out_q;
    end
  end

  assign key_out     = out_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign busy        = (state_q == CHECK);

`ifdef KEY_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  logic [HW-1:0] hcnt_q;
  logic          hdone_q, long_q;

  // Gating with lvl_q lets a release committing at the threshold suppress the strobe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hcnt_q  <= '0;
      hdone_q <= 1'b0;
      long_q  <= 1'b0;
    end else if (!out_q) begin
      hcnt_q  <= '0;
      hdone_q <= 1'b0;
      long_q  <= 1'b0;
    end else if (!hdone_q && hcnt_q == HOLD_LAST) begin
      long_q  <= lvl_q;
      hdone_q <= 1'b1;
    end else begin
      long_q <= 1'b0;
      if (!hdone_q) hcnt_q <= hcnt_q + HW'(1);
    end
  end
  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif
endmodule

module key_debounce_bank #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACTIVE_LOW      = 0,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              key_busy
);
  logic [N_KEYS-1:0] busy;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_lane (
      .clk        (clk),
      .nrst       (nrst),
      .key_in     (key_in[k]),
      .key_out    (key_out[k]),
      .key_press  (key_press[k]),
      .key_release(key_release[k]),
      .key_long   (key_long[k]),
      .busy       (busy[k])
    );
  end

  assign key_busy = |busy;
endmodule

// File: tb/tb_key_debounce_bank.sv
// Random + directed bench for key_debounce_bank; reference model is a stability-run counter over sampled pins.
module tb_key_debounce_bank;
  localparam int N = 4, D = 4, L = 16;

  logic         clk = 1'b0, nrst = 1'b0;
  logic [N-1:0] key_in = '0, key_in_n;
  logic [N-1:0] a_out, a_press, a_rel, a_long, b_out, b_press, b_rel, b_long;
  logic         a_busy, b_busy;

  assign key_in_n = ~key_in;
  always #5 clk = ~clk;

  key_debounce_bank #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0), .LONG_CYCLES(L)) u_dut_a (
    .clk(clk), .nrst(nrst), .key_in(key_in), .key_out(a_out), .key_press(a_press),
    .key_release(a_rel), .key_long(a_long), .key_busy(a_busy));

  key_debounce_bank #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .LONG_CYCLES(L)) u_dut_b (
    .clk(clk), .nrst(nrst), .key_in(key_in_n), .key_out(b_out), .key_press(b_press),
    .key_release(b_rel), .key_long(b_long), .key_busy(b_busy));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: a level commits once D+1 consecutive pin samples differ from it;
  // the visible outputs trail the model by the sync and output register stages.
  logic [N-1:0] mlvl;
  int           run[N];
  int           hc[N];
  logic [N-1:0] lh[5];
  logic [N-1:0] bh[3];

  task automatic model_reset();
    mlvl = '0;
    for (int k = 0; k < N; k++) begin run[k] = 0; hc[k] = 0; end
    for (int i = 0; i < 5; i++) lh[i] = '0;
    for (int i = 0; i < 3; i++) bh[i] = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] p);
    for (int k = 0; k < N; k++) begin
      if (p[k] != mlvl[k]) begin
        run[k]++;
        if (run[k] == D + 1) begin mlvl[k] = p[k]; run[k] = 0; end
      end else run[k] = 0;
    end
    for (int i = 4; i > 0; i--) lh[i] = lh[i-1];
    lh[0] = mlvl;
    for (int i = 2; i > 0; i--) bh[i] = bh[i-1];
    for (int k = 0; k < N; k++) bh[0][k] = (run[k] > 0);
    for (int k = 0; k < N; k++) hc[k] = lh[3][k] ? hc[k] + 1 : 0;
  endtask

  task automatic check_all();
    logic [N-1:0] e_long;
    for (int k = 0; k < N; k++) begin
`ifdef KEY_LONGPRESS_EN
      e_long[k] = (hc[k] == L + 1);
`else
      e_long[k] = 1'b0;
`endif
    end
    chk("a_out",   a_out,   lh[3]);
    chk("a_press", a_press, lh[3] & ~lh[4]);
    chk("a_rel",   a_rel,   ~lh[3] & lh[4]);
    chk("a_long",  a_long,  e_long);
    chk("a_busy",  a_busy,  |bh[2]);
    chk("b_out",   b_out,   lh[3]);
    chk("b_press", b_press, lh[3] & ~lh[4]);
    chk("b_rel",   b_rel,   ~lh[3] & lh[4]);
    chk("b_long",  b_long,  e_long);
    chk("b_busy",  b_busy,  |bh[2]);
  endtask

  task automatic step(input logic [N-1:0] nxt);
    @(posedge clk);
    if (nrst) model_edge(key_in);
    #1;
    check_all();
    key_in = nxt;
  endtask

  int           rem[N];
  int           nlong, seen;
  logic [N-1:0] cur;

  initial begin
    model_reset();
    #1;
    check_all();
    chk("rst_out", a_out, 0);
    @(posedge clk); #1;
    nrst   = 1'b1;
    key_in = 4'b0001;

    // single press: commit at E0+7
    for (int i = 1; i <= 9; i++) begin
      step(4'b0001);
      if (i == 3) chk("t1_busy", a_busy, 1);
      if (i == 7) chk("t1_early", a_out, 0);
      if (i == 8) begin
        chk("t1_press", a_press, 4'b0001);
        chk("t1_out",   a_out,   4'b0001);
        chk("t1_al_press", b_press, 4'b0001);
      end
      if (i == 9) chk("t1_press_1cyc", a_press, 0);
    end

    // glitch on key 1
    key_in = 4'b0011;
    step(4'b0011); step(4'b0011); step(4'b0001);
    for (int i = 0; i < 10; i++) step(4'b1001);
    chk("t2_glitch", a_out[1], 0);

    // bounce on key 2 then steady
    key_in = 4'b1101;
    step(4'b1001); step(4'b1101);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b1101);
      if (a_press[2]) seen++;
    end
    chk("t3_one_press", seen, 1);

    // simultaneous release of keys 0 and 3 (key 2 held)
    key_in = 4'b0100;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0100);
      if (a_rel != 0) begin seen++; chk("t4_rel", a_rel, 4'b1001); end
    end
    chk("t4_seen", seen, 1);
    chk("t4_out", a_out, 4'b0100);

    // long hold on key 0
    key_in = 4'b0101;
    nlong = 0;
    for (int i = 0; i < 50; i++) begin
      step(4'b0101);
      if (a_long[0]) nlong++;
    end
`ifdef KEY_LONGPRESS_EN
    chk("t5_nlong", nlong, 1);
`else
    chk("t5_nlong", nlong, 0);
`endif

    // reset mid-CHECK on key 1
    key_in = 4'b0111;
    step(4'b0111); step(4'b0111); step(4'b0111);
    chk("t6_busy", a_busy, 1);
    nrst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_out", a_out, 0);
    chk("t6_rst_busy", a_busy, 0);
    step(4'b0111); step(4'b0111);
    nrst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(4'b0111);
      if (i == 7) chk("t6_early", a_out, 0);
      if (i == 8) chk("t6_press", a_press, 4'b0111);
    end

    // random phase
    cur = key_in;
    for (int k = 0; k < N; k++) rem[k] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0) begin
          cur[k] = ~cur[k];
          rem[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 30));
        end
        rem[k]--;
      end
      step(cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
